// File: rtl/axi_master_write_pkg.sv
// Shared types and constants for the single-burst AXI write master.
// Holds FSM states, AXI response/burst encodings and bus widths.
package axi_master_write_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned ID_W   = 12;
  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned LEN_W  = 8;

  typedef enum logic [1:0] {
    StIdle,
    StXfer,
    StResp
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // A response carrying someone else's ID is reported as a slave error.
  function automatic logic [1:0] resolve_resp(input logic [1:0]      bresp,
                                              input logic [ID_W-1:0] bid,
                                              input logic [ID_W-1:0] id);
    return (bid != id) ? AXI_RESP_SLVERR : bresp;
  endfunction

endpackage

// File: rtl/axi_master_write.sv
// AXI write master: one command in, one AW, len+1 W beats streamed straight from the
// user port, then one B response reported as a done pulse.
module axi_master_write
  import axi_master_write_pkg::*;
(
  input  logic              clk,
  input  logic              rst,

  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [2:0]        cmd_size,
  input  logic [1:0]        cmd_burst,
  input  logic [ID_W-1:0]   cmd_id,

  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              wr_valid,
  output logic              wr_ready,

  output logic              m_axi_awvalid,
  input  logic              m_axi_awready,
  output logic [ADDR_W-1:0] m_axi_awaddr,
  output logic [LEN_W-1:0]  m_axi_awlen,
  output logic [2:0]        m_axi_awsize,
  output logic [1:0]        m_axi_awburst,
  output logic [ID_W-1:0]   m_axi_awid,

  output logic              m_axi_wvalid,
  input  logic              m_axi_wready,
  output logic [DATA_W-1:0] m_axi_wdata,
  output logic [STRB_W-1:0] m_axi_wstrb,
  output logic              m_axi_wlast,
  output logic [ID_W-1:0]   m_axi_wid,

  input  logic              m_axi_bvalid,
  output logic              m_axi_bready,
  input  logic [1:0]        m_axi_bresp,
  input  logic [ID_W-1:0]   m_axi_bid,

  output logic              done,
  output logic [1:0]        done_resp,
  output logic [ID_W-1:0]   done_id,
  output logic              busy
);

  state_e            state_q;
  logic              aw_pending_q;
  logic              w_open_q;
  logic              cmd_ready_q;
  logic              bready_q;
  logic              busy_q;
  logic              done_q;
  logic [1:0]        done_resp_q;
  logic [ID_W-1:0]   done_id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  beat_q;

  logic cmd_acc;
  logic aw_hs;
  logic w_hs;
  logic last_hs;
  logic aw_done;
  logic w_done;

  assign cmd_acc = cmd_valid & cmd_ready_q;
  assign aw_hs   = aw_pending_q & m_axi_awready;
  assign w_hs    = m_axi_wvalid & m_axi_wready;
  assign last_hs = w_hs & m_axi_wlast;
  // Either channel may finish first; a channel already finished counts as done.
  assign aw_done = ~aw_pending_q | aw_hs;
  assign w_done  = ~w_open_q | last_hs;

  assign cmd_ready     = cmd_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign done_resp     = done_resp_q;
  assign done_id       = done_id_q;

  assign m_axi_awvalid = aw_pending_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = size_q;
  assign m_axi_awburst = burst_q;
  assign m_axi_awid    = id_q;

  // Zero-latency pass-through: no skid buffer between the user stream and W.
  assign m_axi_wvalid  = wr_valid & w_open_q;
  assign wr_ready      = m_axi_wready & w_open_q;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign m_axi_wlast   = (beat_q == len_q);
  assign m_axi_wid     = id_q;

  assign m_axi_bready  = bready_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      aw_pending_q <= 1'b0;
      w_open_q     <= 1'b0;
      cmd_ready_q  <= 1'b1;
      bready_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      done_resp_q  <= AXI_RESP_OKAY;
      done_id_q    <= '0;
      addr_q       <= '0;
      len_q        <= '0;
      size_q       <= '0;
      burst_q      <= '0;
      id_q         <= '0;
      beat_q       <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Re-opens one cycle after a completion so done never overlaps acceptance.
          cmd_ready_q <= 1'b1;
          if (cmd_acc) begin
            addr_q       <= cmd_addr;
            len_q        <= cmd_len;
            size_q       <= cmd_size;
            burst_q      <= cmd_burst;
            id_q         <= cmd_id;
            beat_q       <= '0;
            aw_pending_q <= 1'b1;
            w_open_q     <= 1'b1;
            cmd_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= StXfer;
          end
        end
        StXfer: begin
          if (aw_hs) begin
            aw_pending_q <= 1'b0;
          end
          if (last_hs) begin
            w_open_q <= 1'b0;
          end else if (w_hs) begin
            beat_q <= beat_q + 8'd1;
          end
          if (aw_done && w_done) begin
            bready_q <= 1'b1;
            state_q  <= StResp;
          end
        end
        StResp: begin
          if (m_axi_bvalid) begin
            done_resp_q <= resolve_resp(m_axi_bresp, m_axi_bid, id_q);
            done_id_q   <= m_axi_bid;
            done_q      <= 1'b1;
            bready_q    <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: doc/axi_master_write.md
AXI_MASTER_WRITE -- requirements
Module: axi_master_write

Interface
REQ-001 SHALL expose: clk  in  1  clock; all logic samples on rising edge.
REQ-002 SHALL expose: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL expose: cmd_valid  in  1  write command offered.
REQ-004 SHALL expose: cmd_ready  out  1  command accepted when high with cmd_valid.
REQ-005 SHALL expose: cmd_addr  in  32, cmd_len  in  8 (beats-1), cmd_size  in  3, cmd_burst  in  2, cmd_id  in  12.
REQ-006 SHALL expose: wr_data  in  32, wr_strb  in  4, wr_valid  in  1, wr_ready  out  1 (user data stream).
REQ-007 SHALL expose AW: m_axi_awvalid out 1, m_axi_awready in 1, m_axi_awaddr out 32, m_axi_awlen out 8, m_axi_awsize out 3, m_axi_awburst out 2, m_axi_awid out 12.
REQ-008 SHALL expose W: m_axi_wvalid out 1, m_axi_wready in 1, m_axi_wdata out 32, m_axi_wstrb out 4, m_axi_wlast out 1, m_axi_wid out 12.
REQ-009 SHALL expose B: m_axi_bvalid in 1, m_axi_bready out 1, m_axi_bresp in 2, m_axi_bid in 12.
REQ-010 SHALL expose: done  out  1  one-cycle completion pulse; done_resp  out  2; done_id  out  12; busy  out  1.

Function
REQ-011 SHALL implement FSM states IDLE, XFER, RESP.
REQ-012 IDLE: cmd_ready=1; on cmd_valid, SHALL latch addr/len/size/burst/id into registers, set aw_pending=1, beat counter=0, go XFER next cycle.
REQ-013 XFER: m_axi_awvalid SHALL equal aw_pending; AW fields driven from latched registers, stable while awvalid high.
REQ-014 aw_pending SHALL clear on the cycle after awvalid&&awready; AW SHALL issue exactly once per command.
REQ-015 W path: m_axi_wvalid = wr_valid in XFER while beats remain; wr_ready = m_axi_wready under same condition; wdata/wstrb pass through combinationally; wid = latched id.
REQ-016 m_axi_wlast SHALL be 1 iff beat counter == latched len.
REQ-017 Beat counter (8 bit) SHALL increment on each wvalid&&wready; no wrap since max 255 == len max.
REQ-018 W beats SHALL be allowed before, during, or after the AW handshake (no ordering dependency).
REQ-019 XFER -> RESP when last-beat handshake and AW done have both occurred (either order, including same cycle).
REQ-020 RESP: m_axi_bready=1; on bvalid SHALL capture bresp/bid into done_resp/done_id, pulse done next cycle, return to IDLE.
REQ-021 bid mismatch with latched id SHALL force done_resp=2'b10 (SLVERR).
REQ-022 awvalid, wvalid, bready SHALL be 0 outside XFER/RESP respectively; cmd_ready 0 outside IDLE.
REQ-023 busy SHALL be 1 in XFER and RESP.
REQ-024 wvalid, once asserted, SHALL not drop before wready only if wr_valid is held by the user; the block adds no buffering (zero-latency pass-through).
REQ-025 New command SHALL be accepted no earlier than the cycle after done.

Reset
REQ-026 On rst: state=IDLE, aw_pending=0, beat counter=0, done=0, done_resp=0, done_id=0, all latched AW registers=0.
REQ-027 Reset mid-transfer SHALL abandon the burst; awvalid/wvalid/bready low the cycle after rst asserts.

Structure
REQ-028 Package axi_master_write_pkg SHALL hold the FSM state enum, AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR and BURST_FIXED/INCR/WRAP constants, width parameters (ADDR 32, DATA 32, ID 12).
REQ-029 Single module; no sub-module required.

Verification
REQ-030 Single-beat: cmd len=0, addr 0x1000, id 0x5; awready/wready always 1, bvalid 1 cycle later bresp=0 -> one AW, one W with wlast=1, done pulse, done_resp=0, done_id=0x5.
REQ-031 Burst len=3, wready toggling 1/0 -> exactly 4 W handshakes, wlast only on 4th, awlen=3 stable until awready.
REQ-032 W before AW: awready held 0 for 10 cycles while all 4 beats complete -> remains XFER until AW handshake, then RESP.
REQ-033 B mismatch: bid=0x7 vs id 0x5, bresp=0 -> done_resp=2'b10.
REQ-034 Back-pressure: bvalid delayed 20 cycles -> bready held 1, cmd_ready 0 throughout.
REQ-035 rst asserted mid-burst after beat 2 -> all valids low next cycle, state IDLE, new command completes normally.
